apb_intercon_rr: RTL and testbench
==================================

Name: apb_intercon_rr

Overview:
Parametrised N-master / M-slave APB interconnect. It is the next-generation replacement for the single-grant, round-robin core-to-peripheral switch between the vmicro16 cores and the SoC peripherals.
- Fair round-robin arbitration with a grant locked for the whole transfer.
- Mask/base address decode from parameters, not fixed macros.
- Separate PRDATA/PREADY per slave.
- PSLVERR for unmapped addresses.
- Optional stall timeout.

Parameters:
- BUS_WIDTH, 16: address and data width.
- MASTER_PORTS, 2: number of upstream masters (cores), 1 or more.
- SLAVE_PORTS, 6: number of downstream slaves, 1 or more.
- SLAVE_BASE, {SLAVE_PORTS*BUS_WIDTH} 0: packed base addresses; slave i occupies slice [i*BUS_WIDTH +: BUS_WIDTH].
- SLAVE_MASK, {SLAVE_PORTS*BUS_WIDTH} 0: packed masks. Slave i hits when (PADDR & MASK_i) == BASE_i.
- TIMEOUT_CYCLES, 255: ACCESS-phase limit. Used only when APB_IC_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- S_PADDR  in  MASTER_PORTS*BUS_WIDTH  master addresses.
- S_PWRITE  in  MASTER_PORTS  master write strobes.
- S_PSELx  in  MASTER_PORTS  master requests.
- S_PENABLE  in  MASTER_PORTS  master enables (ignored; the interconnect generates its own phases).
- S_PWDATA  in  MASTER_PORTS*BUS_WIDTH  master write data.
- S_PRDATA  out  MASTER_PORTS*BUS_WIDTH  read data; only the granted master's slice is nonzero.
- S_PREADY  out  MASTER_PORTS  one-hot completion strobe to the granted master.
- S_PSLVERR  out  MASTER_PORTS  error qualifier; valid with S_PREADY.
- M_PADDR  out  BUS_WIDTH  shared slave address.
- M_PWRITE  out  1  shared write strobe.
- M_PSELx  out  SLAVE_PORTS  one-hot slave select.
- M_PENABLE  out  1  shared enable.
- M_PWDATA  out  BUS_WIDTH  shared write data.
- M_PRDATA  in  SLAVE_PORTS*BUS_WIDTH  per-slave read data.
- M_PREADY  in  SLAVE_PORTS  per-slave ready.
- M_PSLVERR  in  SLAVE_PORTS  per-slave error.

Behaviour:
- Reset: state=IDLE, grant=0, rr_last=MASTER_PORTS-1 (so master 0 has first priority), registered address/data/write=0. All M_* and S_* outputs are 0 and stay 0 while reset is high.
- Reset asserted mid-transfer: the transfer is abandoned with no PREADY to any master. The slave sees PSEL drop.
- FSM: IDLE, SETUP, ACCESS.
- IDLE:
  - If |S_PSELx, pick the first requester after rr_last, in increasing index order with wrap-around.
  - Latch that master's PADDR, PWRITE and PWDATA into registers. Latch the decoded slave index, or a miss flag.
  - Go to SETUP.
  - No request: stay in IDLE with all M_* outputs 0.
- SETUP:
  - M_PSELx = one-hot of the decoded slave; all zero on a miss.
  - M_PENABLE=0; M_PADDR/M_PWDATA/M_PWRITE come from the registers.
  - Always go to ACCESS next cycle.
- ACCESS:
  - M_PENABLE=1; M_PSELx is held.
  - Completion when M_PREADY[sel]=1, or immediately on a miss.
  - On completion, combinationally drive:
    - S_PREADY[grant]=1;
    - S_PRDATA slice = M_PRDATA[sel], or 0 on a miss;
    - S_PSLVERR[grant] = M_PSLVERR[sel], or 1 on a miss.
  - On completion, rr_last<=grant and state<=IDLE.
  - Otherwise stay in ACCESS. Any number of wait states is allowed.
- Latency: request in IDLE to S_PREADY takes 2 cycles with zero wait states. The minimum gap between transfers is 1 IDLE cycle.
- Grant lock: changes on other masters' S_PSELx never affect an in-flight transfer. The granted master's inputs are not re-sampled after IDLE.
- Overlapping decode: the lowest slave index wins. M_PSELx is always one-hot or zero.
- Single master (MASTER_PORTS=1): the grant is fixed at 0 and the arbiter degenerates with no width-0 vectors. Index widths use clog2 with a minimum of 1.
- All masters requesting continuously are served strictly in rotation 0,1,...,N-1,0,...

Optional Feature:
- APB_IC_TIMEOUT_EN defined: a counter clears on entering ACCESS and increments each ACCESS cycle without ready.
  - When it reaches TIMEOUT_CYCLES, complete as a miss: S_PREADY=1, S_PSLVERR=1, S_PRDATA=0.
  - Then M_PSELx drops and the FSM returns to IDLE.
- APB_IC_TIMEOUT_EN undefined: there is no counter, and ACCESS waits indefinitely.

Decomposition:
- Package apb_ic_pkg holds:
  - state encodings IDLE/SETUP/ACCESS;
  - the clog2 helper;
  - the default TIMEOUT_CYCLES;
  - default SoC base/mask constants for GPIO0-2, UART0, REGS0 and BRAM0.
- One sub-module, apb_rr_arbiter, owns rr_last and computes the next grant.
  - Inputs: req vector, advance strobe.
  - Output: grant index.

Test Plan:
- Single master 0 reads slave 2 (BASE 0x00A0, MASK 0xFFF0) at 0x00A5, slave ready in ACCESS with PRDATA=0x1234 -> M_PSELx=0b000100 in SETUP/ACCESS, S_PREADY[0] 2 cycles after request, S_PRDATA[15:0]=0x1234, S_PSLVERR=0.
- Master 1 writes 0xBEEF to 0x0090 with the slave holding PREADY low for 3 cycles -> M_PWDATA=0xBEEF stable throughout, M_PENABLE high for 4 cycles, exactly one S_PREADY[1] pulse.
- Masters 0 and 1 request continuously -> grants alternate 0,1,0,1. A master-0 PSELx toggle during master 1's ACCESS does not change M_PADDR.
- Access to unmapped 0x7000 -> M_PSELx=0 throughout, S_PREADY=1 and S_PSLVERR=1 in the first ACCESS cycle, S_PRDATA=0.
- Reset pulsed in ACCESS -> next cycle all outputs 0, FSM IDLE. With both masters requesting after reset, master 0 is granted first.
- With APB_IC_TIMEOUT_EN and TIMEOUT_CYCLES=8, the slave never readies -> S_PREADY=1, S_PSLVERR=1 after 8 ACCESS cycles, then the FSM is IDLE.

Source files
------------

// File: rtl/apb_ic_pkg.sv
// Shared types, sizing helper and default SoC address map for the APB interconnect.
package apb_ic_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

  // Bits needed to index `value` entries, never less than one.
  function automatic int unsigned clog2_min1(input int unsigned value);
    int unsigned width;
    width = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < value) width = i + 1;
    end
    return width;
  endfunction

  localparam logic [15:0] GPIO0_BASE = 16'h0080;
  localparam logic [15:0] GPIO0_MASK = 16'hFFF0;
  localparam logic [15:0] GPIO1_BASE = 16'h0090;
  localparam logic [15:0] GPIO1_MASK = 16'hFFF0;
  localparam logic [15:0] GPIO2_BASE = 16'h00A0;
  localparam logic [15:0] GPIO2_MASK = 16'hFFF0;
  localparam logic [15:0] UART0_BASE = 16'h00B0;
  localparam logic [15:0] UART0_MASK = 16'hFFF0;
  localparam logic [15:0] REGS0_BASE = 16'h00C0;
  localparam logic [15:0] REGS0_MASK = 16'hFFF0;
  localparam logic [15:0] BRAM0_BASE = 16'h1000;
  localparam logic [15:0] BRAM0_MASK = 16'hF000;

  localparam logic [6*16-1:0] SOC_SLAVE_BASE =
    {BRAM0_BASE, REGS0_BASE, UART0_BASE, GPIO2_BASE, GPIO1_BASE, GPIO0_BASE};
  localparam logic [6*16-1:0] SOC_SLAVE_MASK =
    {BRAM0_MASK, REGS0_MASK, UART0_MASK, GPIO2_MASK, GPIO1_MASK, GPIO0_MASK};

endpackage

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter: owns the last-served index and proposes the next grant.
module apb_rr_arbiter
  import apb_ic_pkg::*;
#(
  parameter int unsigned PORTS = 2,
  localparam int unsigned IW = clog2_min1(PORTS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PORTS-1:0] req,
  input  logic             advance,
  output logic [IW-1:0]    grant
);

  logic [IW-1:0] rr_last;
  logic          found;
  int unsigned   idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 1; i <= PORTS; i++) begin
      idx = (32'(rr_last) + i) % PORTS;
      if (!found && req[idx]) begin
        found = 1'b1;
        grant = IW'(idx);
      end
    end
  end

  // Recorded at grant time rather than completion: no new pick can happen
  // while a transfer is in flight, and reset restores the initial pointer.
  always_ff @(posedge clk) begin
    if (reset) rr_last <= IW'(PORTS - 1);
    else if (advance) rr_last <= grant;
  end

endmodule

// File: rtl/apb_intercon_rr.sv
// N-master / M-slave APB interconnect with round-robin arbitration and mask/base decode.
// Optional ACCESS stall timeout enabled by defining APB_IC_TIMEOUT_EN.
module apb_intercon_rr
  import apb_ic_pkg::*;
#(
  parameter int unsigned BUS_WIDTH    = 16,
  parameter int unsigned MASTER_PORTS = 2,
  parameter int unsigned SLAVE_PORTS  = 6,
  parameter logic [SLAVE_PORTS*BUS_WIDTH-1:0] SLAVE_BASE = '0,
  parameter logic [SLAVE_PORTS*BUS_WIDTH-1:0] SLAVE_MASK = '0,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PADDR,
  input  logic [MASTER_PORTS-1:0]           S_PWRITE,
  input  logic [MASTER_PORTS-1:0]           S_PSELx,
  input  logic [MASTER_PORTS-1:0]           S_PENABLE,
  input  logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PWDATA,
  output logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PRDATA,
  output logic [MASTER_PORTS-1:0]           S_PREADY,
  output logic [MASTER_PORTS-1:0]           S_PSLVERR,
  output logic [BUS_WIDTH-1:0]              M_PADDR,
  output logic                              M_PWRITE,
  output logic [SLAVE_PORTS-1:0]            M_PSELx,
  output logic                              M_PENABLE,
  output logic [BUS_WIDTH-1:0]              M_PWDATA,
  input  logic [SLAVE_PORTS*BUS_WIDTH-1:0]  M_PRDATA,
  input  logic [SLAVE_PORTS-1:0]            M_PREADY,
  input  logic [SLAVE_PORTS-1:0]            M_PSLVERR
);

  localparam int unsigned MW = clog2_min1(MASTER_PORTS);
  localparam int unsigned SW = clog2_min1(SLAVE_PORTS);

  state_t               state;
  logic [MW-1:0]        grant_q;
  logic [MW-1:0]        next_grant;
  logic [BUS_WIDTH-1:0] addr_q;
  logic [BUS_WIDTH-1:0] wdata_q;
  logic                 write_q;
  logic [SW-1:0]        sel_q;
  logic                 miss_q;

  logic                 start;
  logic [BUS_WIDTH-1:0] req_addr;
  logic                 dec_hit;
  logic [SW-1:0]        dec_sel;
  logic                 bus_active;
  logic                 in_access;
  logic                 slave_ready;
  logic                 timed_out;
  logic                 abort;
  logic                 done;
  logic [BUS_WIDTH-1:0] rdata;
  logic                 err;
  logic                 unused_penable;

  assign unused_penable = ^S_PENABLE;
  assign start = (state == IDLE) && (|S_PSELx);

  apb_rr_arbiter #(
    .PORTS(MASTER_PORTS)
  ) u_arbiter (
    .clk    (clk),
    .reset  (reset),
    .req    (S_PSELx),
    .advance(start),
    .grant  (next_grant)
  );

  assign req_addr = S_PADDR[next_grant*BUS_WIDTH +: BUS_WIDTH];

  // Ascending scan with a first-hit guard so the lowest slave index wins overlaps.
  always_comb begin
    dec_hit = 1'b0;
    dec_sel = '0;
    for (int unsigned i = 0; i < SLAVE_PORTS; i++) begin
      if (!dec_hit && ((req_addr & SLAVE_MASK[i*BUS_WIDTH +: BUS_WIDTH]) ==
                       SLAVE_BASE[i*BUS_WIDTH +: BUS_WIDTH])) begin
        dec_hit = 1'b1;
        dec_sel = SW'(i);
      end
    end
  end

  assign slave_ready = M_PREADY[sel_q];

`ifdef APB_IC_TIMEOUT_EN
  localparam int unsigned TW = clog2_min1(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] timer;

  always_ff @(posedge clk) begin
    if (reset || state == SETUP) timer <= '0;
    else if (state == ACCESS && !slave_ready) timer <= timer + 1'b1;
  end

  assign timed_out = (state == ACCESS) && (timer == TW'(TIMEOUT_CYCLES));
`else
  assign timed_out = 1'b0;
`endif

  assign bus_active = !reset && (state != IDLE);
  assign in_access  = !reset && (state == ACCESS);
  assign abort      = miss_q || timed_out;
  assign done       = in_access && (abort || slave_ready);
  assign rdata      = abort ? '0 : M_PRDATA[sel_q*BUS_WIDTH +: BUS_WIDTH];
  assign err        = abort || M_PSLVERR[sel_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      grant_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      sel_q   <= '0;
      miss_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            grant_q <= next_grant;
            addr_q  <= req_addr;
            wdata_q <= S_PWDATA[next_grant*BUS_WIDTH +: BUS_WIDTH];
            write_q <= S_PWRITE[next_grant];
            sel_q   <= dec_sel;
            miss_q  <= !dec_hit;
            state   <= SETUP;
          end
        end
        SETUP:   state <= ACCESS;
        ACCESS:  if (done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign M_PADDR   = bus_active ? addr_q : '0;
  assign M_PWDATA  = bus_active ? wdata_q : '0;
  assign M_PWRITE  = bus_active && write_q;
  assign M_PENABLE = in_access;
  assign M_PSELx   = (bus_active && !miss_q) ? (SLAVE_PORTS'(1) << sel_q) : '0;

  assign S_PREADY  = done ? (MASTER_PORTS'(1) << grant_q) : '0;
  assign S_PSLVERR = (done && err) ? (MASTER_PORTS'(1) << grant_q) : '0;

  always_comb begin
    S_PRDATA = '0;
    if (done) S_PRDATA[grant_q*BUS_WIDTH +: BUS_WIDTH] = rdata;
  end

endmodule

// File: tb/tb_apb_intercon_rr.sv
// Scoreboard bench for apb_intercon_rr: two masters, SoC slave map, simple wait-state slave model.
module tb_apb_intercon_rr;
  import apb_ic_pkg::*;

  localparam int BW = 16;
  localparam int NM = 2;
  localparam int NS = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NM*BW-1:0] S_PADDR = '0;
  logic [NM-1:0]    S_PWRITE = '0;
  logic [NM-1:0]    S_PSELx = '0;
  logic [NM-1:0]    S_PENABLE = '0;
  logic [NM*BW-1:0] S_PWDATA = '0;
  logic [NM*BW-1:0] S_PRDATA;
  logic [NM-1:0]    S_PREADY;
  logic [NM-1:0]    S_PSLVERR;
  logic [BW-1:0]    M_PADDR;
  logic             M_PWRITE;
  logic [NS-1:0]    M_PSELx;
  logic             M_PENABLE;
  logic [BW-1:0]    M_PWDATA;
  logic [NS*BW-1:0] M_PRDATA;
  logic [NS-1:0]    M_PREADY;
  logic [NS-1:0]    M_PSLVERR;

  apb_intercon_rr #(
    .BUS_WIDTH     (BW),
    .MASTER_PORTS  (NM),
    .SLAVE_PORTS   (NS),
    .SLAVE_BASE    (SOC_SLAVE_BASE),
    .SLAVE_MASK    (SOC_SLAVE_MASK),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset),
    .S_PADDR(S_PADDR), .S_PWRITE(S_PWRITE), .S_PSELx(S_PSELx), .S_PENABLE(S_PENABLE),
    .S_PWDATA(S_PWDATA), .S_PRDATA(S_PRDATA), .S_PREADY(S_PREADY), .S_PSLVERR(S_PSLVERR),
    .M_PADDR(M_PADDR), .M_PWRITE(M_PWRITE), .M_PSELx(M_PSELx), .M_PENABLE(M_PENABLE),
    .M_PWDATA(M_PWDATA), .M_PRDATA(M_PRDATA), .M_PREADY(M_PREADY), .M_PSLVERR(M_PSLVERR)
  );

  always #5 clk = ~clk;

  // Slave model: readies after wait_n ACCESS cycles unless stalled.
  logic          stall = 1'b0;
  int            wait_n = 0;
  int            wcnt = 0;
  logic [BW-1:0] rd_val = '0;
  logic          slverr_val = 1'b0;

  always @(posedge clk) begin
    if (M_PENABLE && !(|M_PREADY)) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  assign M_PREADY  = (M_PENABLE && !stall && wcnt >= wait_n) ? M_PSELx : '0;
  assign M_PRDATA  = {NS{rd_val}};
  assign M_PSLVERR = {NS{slverr_val}};

  typedef struct {
    int            master;
    logic [BW-1:0] addr;
    logic [NS-1:0] psel;
    logic          write;
    logic [BW-1:0] wdata;
    logic [BW-1:0] rdata;
    logic          err;
  } exp_t;

  typedef struct {
    logic [NM-1:0]    pready;
    logic [NM-1:0]    pslverr;
    logic [NM*BW-1:0] prdata;
    logic [BW-1:0]    paddr;
    logic [BW-1:0]    pwdata;
    logic [NS-1:0]    psel;
    logic             penable;
    logic             pwrite;
    int               cycle;
  } obs_t;

  exp_t sb[$];
  obs_t obs[$];
  int   cyc = 0;
  int   done_count = 0;
  int   en_cnt = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   last_cycle = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    obs_t o;
    if (M_PENABLE) en_cnt = en_cnt + 1;
    if (|S_PREADY) begin
      o.pready  = S_PREADY;
      o.pslverr = S_PSLVERR;
      o.prdata  = S_PRDATA;
      o.paddr   = M_PADDR;
      o.pwdata  = M_PWDATA;
      o.psel    = M_PSELx;
      o.penable = M_PENABLE;
      o.pwrite  = M_PWRITE;
      o.cycle   = cyc;
      obs.push_back(o);
      done_count = done_count + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_master(input int m, input logic sel, input logic wr,
                            input logic [BW-1:0] addr, input logic [BW-1:0] wdata);
    S_PSELx[m] = sel;
    S_PWRITE[m] = wr;
    S_PADDR[m*BW +: BW] = addr;
    S_PWDATA[m*BW +: BW] = wdata;
  endtask

  task automatic push_exp(input int m, input logic [BW-1:0] addr, input logic [NS-1:0] psel,
                          input logic wr, input logic [BW-1:0] wdata,
                          input logic [BW-1:0] rdata, input logic err);
    exp_t e;
    e.master = m; e.addr = addr; e.psel = psel; e.write = wr;
    e.wdata = wdata; e.rdata = rdata; e.err = err;
    sb.push_back(e);
  endtask

  task automatic drain();
    obs_t o;
    exp_t e;
    logic [31:0] one_hot;
    while (obs.size() > 0) begin
      o = obs.pop_front();
      if (sb.size() == 0) begin
        check("spurious_pready", 32'(o.pready), 0);
      end else begin
        e = sb.pop_front();
        one_hot = 32'd1 << e.master;
        check("grant", 32'(o.pready), one_hot);
        check("paddr", 32'(o.paddr), 32'(e.addr));
        check("psel", 32'(o.psel), 32'(e.psel));
        check("penable", 32'(o.penable), 1);
        check("pwrite", 32'(o.pwrite), 32'(e.write));
        if (e.write) check("pwdata", 32'(o.pwdata), 32'(e.wdata));
        check("prdata", 32'(o.prdata[e.master*BW +: BW]), 32'(e.rdata));
        check("prdata_other", 32'(o.prdata[(1-e.master)*BW +: BW]), 0);
        check("pslverr", 32'(o.pslverr), e.err ? one_hot : 0);
        last_cycle = o.cycle;
      end
    end
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int n = 0;
    while (done_count < target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_done_count"}, 32'(done_count), 32'(target));
    drain();
    check({tag, "_sb_empty"}, 32'(sb.size()), 0);
    sb.delete();
  endtask

  function automatic logic any_out();
    return |{S_PRDATA, S_PREADY, S_PSLVERR, M_PADDR, M_PWRITE, M_PSELx, M_PENABLE, M_PWDATA};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int req_cyc;
    int e0;

    set_master(0, 1'b1, 1'b0, 16'h00A5, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outs", 32'(any_out()), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    set_master(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("idle_outs", 32'(any_out()), 0);
    @(posedge clk); #1;
    base = done_count;

    // Read slave 2, zero wait states
    rd_val = 16'h1234;
    push_exp(0, 16'h00A5, 6'b000100, 1'b0, '0, 16'h1234, 1'b0);
    set_master(0, 1'b1, 1'b0, 16'h00A5, '0);
    req_cyc = cyc;
    @(posedge clk); #1;
    check("t1_setup_psel", 32'(M_PSELx), 32'h04);
    check("t1_setup_penable", 32'(M_PENABLE), 0);
    base += 1;
    wait_done(base, 10, "t1");
    set_master(0, 1'b0, 1'b0, '0, '0);
    check("t1_latency", 32'(last_cycle - req_cyc), 2);

    // Write with three wait states
    rd_val = '0;
    wait_n = 3;
    e0 = en_cnt;
    push_exp(1, 16'h0090, 6'b000010, 1'b1, 16'hBEEF, '0, 1'b0);
    set_master(1, 1'b1, 1'b1, 16'h0090, 16'hBEEF);
    repeat (3) begin @(posedge clk); #1; end
    check("t2_wdata_mid", 32'(M_PWDATA), 32'hBEEF);
    base += 1;
    wait_done(base, 20, "t2");
    set_master(1, 1'b0, 1'b0, '0, '0);
    repeat (3) begin @(posedge clk); #1; end
    check("t2_en_cycles", 32'(en_cnt - e0), 4);
    check("t2_one_pulse", 32'(done_count), 32'(base));
    wait_n = 0;

    // Both masters requesting continuously: strict rotation
    slverr_val = 1'b1;
    rd_val = 16'h5A5A;
    set_master(0, 1'b1, 1'b0, 16'h00C4, '0);
    set_master(1, 1'b1, 1'b0, 16'h1234, '0);
    for (int i = 0; i < 2; i++) begin
      push_exp(0, 16'h00C4, 6'b010000, 1'b0, '0, 16'h5A5A, 1'b1);
      push_exp(1, 16'h1234, 6'b100000, 1'b0, '0, 16'h5A5A, 1'b1);
    end
    base += 4;
    wait_done(base, 40, "t3");
    set_master(0, 1'b0, 1'b0, '0, '0);
    set_master(1, 1'b0, 1'b0, '0, '0);
    slverr_val = 1'b0;
    @(posedge clk); #1;

    // Master 0 toggles while master 1's transfer is in ACCESS
    wait_n = 3;
    push_exp(1, 16'h00B2, 6'b001000, 1'b0, '0, 16'h5A5A, 1'b0);
    set_master(1, 1'b1, 1'b0, 16'h00B2, '0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      set_master(0, (i % 2) == 0, 1'b0, 16'h00C0 + 16'(i), '0);
      @(posedge clk); #1;
      check("t3_paddr_locked", 32'(M_PADDR), 32'h00B2);
    end
    set_master(0, 1'b0, 1'b0, '0, '0);
    base += 1;
    wait_done(base, 20, "t3b");
    set_master(1, 1'b0, 1'b0, '0, '0);
    wait_n = 0;
    @(posedge clk); #1;

    // Unmapped address
    rd_val = 16'hFFFF;
    push_exp(0, 16'h7000, 6'b000000, 1'b0, '0, '0, 1'b1);
    set_master(0, 1'b1, 1'b0, 16'h7000, '0);
    req_cyc = cyc;
    @(posedge clk); #1;
    check("t4_setup_psel", 32'(M_PSELx), 0);
    base += 1;
    wait_done(base, 10, "t4");
    set_master(0, 1'b0, 1'b0, '0, '0);
    check("t4_latency", 32'(last_cycle - req_cyc), 2);
    @(posedge clk); #1;

    // Reset pulsed while in ACCESS
    stall = 1'b1;
    set_master(0, 1'b1, 1'b0, 16'h00A5, '0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t5_in_access", 32'(M_PENABLE), 1);
    reset = 1'b1;
    set_master(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("t5_outs_in_reset", 32'(any_out()), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    stall = 1'b0;
    @(negedge clk);
    check("t5_outs_after_reset", 32'(any_out()), 0);
    check("t5_no_pready", 32'(done_count), 32'(base));
    @(posedge clk); #1;
    rd_val = 16'h0F0F;
    push_exp(0, 16'h00A5, 6'b000100, 1'b0, '0, 16'h0F0F, 1'b0);
    push_exp(1, 16'h0090, 6'b000010, 1'b0, '0, 16'h0F0F, 1'b0);
    set_master(0, 1'b1, 1'b0, 16'h00A5, '0);
    set_master(1, 1'b1, 1'b0, 16'h0090, '0);
    base += 2;
    wait_done(base, 20, "t5");
    set_master(0, 1'b0, 1'b0, '0, '0);
    set_master(1, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;

`ifdef APB_IC_TIMEOUT_EN
    stall = 1'b1;
    push_exp(0, 16'h00A5, 6'b000100, 1'b0, '0, '0, 1'b1);
    set_master(0, 1'b1, 1'b0, 16'h00A5, '0);
    req_cyc = cyc;
    base += 1;
    wait_done(base, 20, "t6");
    set_master(0, 1'b0, 1'b0, '0, '0);
    check("t6_latency", 32'(last_cycle - req_cyc), 10);
    @(negedge clk);
    check("t6_idle_psel", 32'(M_PSELx), 0);
    check("t6_idle_penable", 32'(M_PENABLE), 0);
    stall = 1'b0;
    @(posedge clk); #1;
`endif

    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
